// File: rtl/rvx_uart_debug_bridge.sv
// UART-to-bus debug bridge: decodes 8N1 read/write command frames from a host and
// issues single RVX bus requests, replying with ACK (+read data) or NAK.
module rvx_uart_debug_bridge #(
   parameter int unsigned CLOCKS_PER_BAUD = 868,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic [31:0] rw_address,
   output logic [31:0] write_data,
   output logic [3:0]  write_strobe,
   output logic        write_request,
   input  logic        write_response,
   output logic        read_request,
   input  logic [31:0] read_data,
   input  logic        read_response,
   output logic        busy
);

   localparam int unsigned BW = $clog2(CLOCKS_PER_BAUD);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLOCKS_PER_BAUD / 2 - 1);
   // The request cycle itself counts toward the timeout budget.
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
   typedef enum logic [2:0] {StCmd, StAddr, StData, StReq, StWait, StReply} state_t;

   logic          rx_meta, rx_sync, rx_prev;
   rx_state_t     rx_state;
   logic [BW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_valid, rx_error;

   state_t        state;
   logic          is_write;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [BW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [39:0]   reply_sr;
   logic [2:0]    reply_left;
   logic          response_hit;

   assign response_hit = is_write ? write_response : read_response;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         {rx_meta, rx_sync, rx_prev} <= 3'b111;
      end else begin
         {rx_meta, rx_sync, rx_prev} <= {uart_rx, rx_meta, rx_sync};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_state <= RxIdle;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
         rx_error <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_error <= 1'b0;
         case (rx_state)
            RxIdle: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= RxStart;
                  rx_cnt   <= '0;
               end
            end
            RxStart: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  // Line back high at mid start bit: treat as a glitch.
                  rx_state <= rx_sync ? RxIdle : RxData;
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
            RxData: begin
               if (rx_cnt == BAUD_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= RxStop;
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
            RxStop: begin
               if (rx_cnt == BAUD_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= RxIdle;
                  rx_valid <= rx_sync;
                  rx_error <= !rx_sync;
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
            default: rx_state <= RxIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= StCmd;
         is_write      <= 1'b0;
         byte_cnt      <= '0;
         tmo_cnt       <= '0;
         tx_cnt        <= '0;
         tx_bit        <= '0;
         reply_sr      <= '0;
         reply_left    <= '0;
         uart_tx       <= 1'b1;
         busy          <= 1'b0;
         rw_address    <= '0;
         write_data    <= '0;
         write_strobe  <= '0;
         write_request <= 1'b0;
         read_request  <= 1'b0;
      end else begin
         read_request  <= 1'b0;
         write_request <= 1'b0;
         write_strobe  <= 4'h0;
         case (state)
            StCmd: begin
               if (rx_valid) begin
                  if (rx_shift == CMD_READ || rx_shift == CMD_WRITE) begin
                     is_write <= (rx_shift == CMD_WRITE);
                     byte_cnt <= '0;
                     busy     <= 1'b1;
                     state    <= StAddr;
                  end else begin
                     reply_sr   <= {32'h0, NAK};
                     reply_left <= 3'd1;
                     tx_cnt     <= '0;
                     tx_bit     <= '0;
                     uart_tx    <= 1'b0;
                     state      <= StReply;
                  end
               end
            end
            StAddr: begin
               if (rx_error) begin
                  busy  <= 1'b0;
                  state <= StCmd;
               end else if (rx_valid) begin
                  rw_address[8*byte_cnt +: 8] <= rx_shift;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (is_write) begin
                        state <= StData;
                     end else begin
                        read_request <= 1'b1;
                        state        <= StReq;
                     end
                  end
               end
            end
            StData: begin
               if (rx_error) begin
                  busy  <= 1'b0;
                  state <= StCmd;
               end else if (rx_valid) begin
                  write_data[8*byte_cnt +: 8] <= rx_shift;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     write_request <= 1'b1;
                     write_strobe  <= 4'hF;
                     state         <= StReq;
                  end
               end
            end
            StReq: begin
               tmo_cnt <= '0;
               state   <= StWait;
            end
            StWait: begin
               // A response in the timeout cycle still wins.
               if (response_hit) begin
                  reply_sr   <= is_write ? {32'h0, ACK} : {read_data, ACK};
                  reply_left <= is_write ? 3'd1 : 3'd5;
                  tx_cnt     <= '0;
                  tx_bit     <= '0;
                  uart_tx    <= 1'b0;
                  state      <= StReply;
               end else if (tmo_cnt == TMO_LAST) begin
                  reply_sr   <= {32'h0, NAK};
                  reply_left <= 3'd1;
                  tx_cnt     <= '0;
                  tx_bit     <= '0;
                  uart_tx    <= 1'b0;
                  state      <= StReply;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            StReply: begin
               if (tx_cnt != BAUD_LAST) begin
                  tx_cnt <= tx_cnt + BW'(1);
               end else begin
                  tx_cnt <= '0;
                  if (tx_bit == 4'd9) begin
                     if (reply_left == 3'd1) begin
                        uart_tx <= 1'b1;
                        busy    <= 1'b0;
                        state   <= StCmd;
                     end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        reply_left <= reply_left - 3'd1;
                        reply_sr   <= {8'h00, reply_sr[39:8]};
                        tx_bit     <= '0;
                        uart_tx    <= 1'b0;
                     end
                  end else begin
                     tx_bit  <= tx_bit + 4'd1;
                     uart_tx <= (tx_bit == 4'd8) ? 1'b1 : reply_sr[tx_bit[2:0]];
                  end
               end
            end
            default: state <= StCmd;
         endcase
      end
   end

endmodule
